// File: rtl/uesprit_corr_tx_pkg.sv
// Shared constants for the unitary-ESPRIT correlation transmit path.
// State codes, frame length and header field positions.
package uesprit_corr_tx_pkg;

    localparam int FRAME_WORDS = 5;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_R11   = 3'd2;
    localparam logic [2:0] S_R22   = 3'd3;
    localparam logic [2:0] S_R12RE = 3'd4;
    localparam logic [2:0] S_R12IM = 3'(FRAME_WORDS);

    localparam int HDR_SYNC_MSB = 31;
    localparam int HDR_SYNC_LSB = 16;
    localparam int HDR_CNT_MSB  = 15;
    localparam int HDR_CNT_LSB  = 0;

    function automatic logic [31:0] hdr_word(
        input logic [15:0] sync,
        input logic [15:0] cnt
    );
        logic [31:0] w;
        w = '0;
        w[HDR_SYNC_MSB:HDR_SYNC_LSB] = sync;
        w[HDR_CNT_MSB:HDR_CNT_LSB]   = cnt;
        return w;
    endfunction

endpackage

// File: rtl/uesprit_corr_tx_corr_set_buf.sv
// Active + shadow holding registers for one correlation set each.
// Handles capture, promotion at end of frame, and drop accounting.
module corr_set_buf #(
    parameter int W         = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4*W-1:0]       din_set,
    input  logic                 din_valid,
    input  logic                 busy,
    input  logic                 eof,
    input  logic                 ovf_clr,
    output logic [4*W-1:0]       act_set,
    output logic                 sh_full,
    output logic                 ovf,
    output logic [CNT_WIDTH-1:0] drop_cnt
);

    logic [4*W-1:0] sh_set;
    logic           promote;
    logic           ld_act;
    logic           ld_sh;
    logic           drop;

    assign promote = eof && sh_full;
    assign ld_act  = (din_valid && (!busy || eof)) || promote;
    assign ld_sh   = din_valid && busy && (eof ? sh_full : !sh_full);
    assign drop    = din_valid && busy && !eof && sh_full;

    // Active/shadow register pair; shadow wins promotion over a fresh set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_set <= '0;
            sh_set  <= '0;
            sh_full <= 1'b0;
        end else begin
            if (ld_act)
                act_set <= promote ? sh_set : din_set;
            if (ld_sh)
                sh_set <= din_set;
            if (ld_sh)
                sh_full <= 1'b1;
            else if (promote)
                sh_full <= 1'b0;
        end
    end

    // Sticky overflow flag and saturating drop counter; a drop beats a clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (drop)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
            if (drop && (drop_cnt != '1))
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uesprit_corr_tx.sv
// Transmit end of the scalar unitary-ESPRIT correlation accumulator.
// Frames each 2x2 correlation set as HDR,R11,R22,R12RE,R12IM on a valid/ready stream.
module uesprit_corr_tx
    import uesprit_corr_tx_pkg::*;
#(
    parameter int          DIN_WIDTH = 32,
    parameter logic [15:0] SYNC_WORD = 16'hA55A,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIN_WIDTH-1:0] r11,
    input  logic [DIN_WIDTH-1:0] r22,
    input  logic [DIN_WIDTH-1:0] r12_re,
    input  logic [DIN_WIDTH-1:0] r12_im,
    input  logic                 din_valid,
    output logic [DIN_WIDTH-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 dout_last,
    input  logic                 ovf_clr,
    output logic                 ovf,
    output logic [CNT_WIDTH-1:0] drop_cnt
);

    localparam int W = DIN_WIDTH;

    logic [2:0]           state;
    logic [2:0]           nxt;
    logic [CNT_WIDTH-1:0] frame_cnt;
    logic [4*W-1:0]       act_set;
    logic                 sh_full;
    logic                 hs;
    logic                 busy;
    logic                 eof;

    assign busy       = (state != S_IDLE);
    assign dout_valid = busy;
    assign hs         = dout_valid && dout_ready;
    assign eof        = hs && (state == S_R12IM);

    corr_set_buf #(
        .W         (W),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .din_set   ({r11, r22, r12_re, r12_im}),
        .din_valid (din_valid),
        .busy      (busy),
        .eof       (eof),
        .ovf_clr   (ovf_clr),
        .act_set   (act_set),
        .sh_full   (sh_full),
        .ovf       (ovf),
        .drop_cnt  (drop_cnt)
    );

    // Next state: step one word per handshake, chain frames when a set is waiting
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (din_valid) nxt = S_HDR;
            S_R12IM: if (hs) nxt = (sh_full || din_valid) ? S_HDR : S_IDLE;
            default: if (hs) nxt = state + 3'd1;
        endcase
    end

    // State register and count of completed frames
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            frame_cnt <= '0;
        end else begin
            state <= nxt;
            if (eof)
                frame_cnt <= frame_cnt + 1'b1;
        end
    end

    // Output word selected purely from state, so it holds through stalls
    always_comb begin
        dout      = '0;
        dout_last = 1'b0;
        case (state)
            S_HDR:   dout = W'(hdr_word(SYNC_WORD, 16'(frame_cnt)));
            S_R11:   dout = act_set[4*W-1:3*W];
            S_R22:   dout = act_set[3*W-1:2*W];
            S_R12RE: dout = act_set[2*W-1:W];
            S_R12IM: begin
                dout      = act_set[W-1:0];
                dout_last = 1'b1;
            end
            default: dout = '0;
        endcase
    end

endmodule

// File: tb/tb_uesprit_corr_tx.sv
// Directed bench for uesprit_corr_tx.
// Expected frames are built from hand-computed words and compared in order.
module tb_uesprit_corr_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] r11 = '0;
    logic [31:0] r22 = '0;
    logic [31:0] r12_re = '0;
    logic [31:0] r12_im = '0;
    logic        din_valid = 1'b0;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready = 1'b1;
    logic        dout_last;
    logic        ovf_clr = 1'b0;
    logic        ovf;
    logic [15:0] drop_cnt;

    int vectors = 0;
    int errs = 0;
    int cyc = 0;

    logic [32:0] got_q[$];
    int          got_c[$];
    logic [32:0] exp_q[$];
    logic        stalled = 1'b0;
    logic [32:0] held = '0;

    uesprit_corr_tx dut (
        .clk        (clk),
        .rst        (rst),
        .r11        (r11),
        .r22        (r22),
        .r12_re     (r12_re),
        .r12_im     (r12_im),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .ovf_clr    (ovf_clr),
        .ovf        (ovf),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // Record accepted words and check that stalled words are held
    always @(negedge clk) begin
        if (!rst) begin
            stalled <= 1'b0;
        end else begin
            if (stalled) begin
                chk("hold_valid", 64'(dout_valid), 64'd1);
                chk("hold_word", 64'({dout_last, dout}), 64'(held));
            end
            if (dout_valid && dout_ready) begin
                got_q.push_back({dout_last, dout});
                got_c.push_back(cyc);
            end
            stalled <= dout_valid && !dout_ready;
            held    <= {dout_last, dout};
        end
    end

    task automatic send(input logic [31:0] a, b, c, d, output int t);
        @(posedge clk); #1;
        r11 = a; r22 = b; r12_re = c; r12_im = d;
        din_valid = 1'b1;
        t = cyc;
        @(posedge clk); #1;
        din_valid = 1'b0;
    endtask

    task automatic exp_frame(input logic [15:0] fc, input logic [31:0] a, b, c, d);
        exp_q.push_back({1'b0, 16'hA55A, fc});
        exp_q.push_back({1'b0, a});
        exp_q.push_back({1'b0, b});
        exp_q.push_back({1'b0, c});
        exp_q.push_back({1'b1, d});
    endtask

    task automatic clr_q();
        got_q.delete();
        got_c.delete();
        exp_q.delete();
    endtask

    task automatic drain(input bit bp);
        logic [15:0] pat;
        int n;
        pat = 16'b1001_0110_1100_1001;
        for (int k = 0; k < 300 && got_q.size() < exp_q.size(); k++) begin
            @(posedge clk); #1;
            if (bp) dout_ready = pat[k % 16];
        end
        dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("nwords", 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("word%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  t0;
        int  t1;
        bit  hit;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(dout_valid), 64'd0);
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_last", 64'(dout_last), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        rst = 1'b1;

        // Single set, ready held high
        send(32'h10, 32'h20, 32'hFFFF_FFF0, 32'h5, t0);
        exp_frame(16'h0000, 32'h10, 32'h20, 32'hFFFF_FFF0, 32'h5);
        drain(1'b0);
        for (int i = 0; i < got_c.size(); i++)
            chk($sformatf("t1_cyc%0d", i), 64'(got_c[i]), 64'(t0 + 1 + i));
        clr_q();

        // Backpressure on ready
        dout_ready = 1'b0;
        send(32'h1111_1111, 32'h2222_2222, 32'h8000_0000, 32'h7FFF_FFFF, t0);
        exp_frame(16'h0001, 32'h1111_1111, 32'h2222_2222, 32'h8000_0000, 32'h7FFF_FFFF);
        drain(1'b1);
        clr_q();

        // Two sets three cycles apart, frames back to back
        send(32'hA1, 32'hA2, 32'hA3, 32'hA4, t0);
        @(posedge clk);
        send(32'hB1, 32'hB2, 32'hB3, 32'hB4, t1);
        chk("t3_gap", 64'(t1 - t0), 64'd3);
        exp_frame(16'h0002, 32'hA1, 32'hA2, 32'hA3, 32'hA4);
        exp_frame(16'h0003, 32'hB1, 32'hB2, 32'hB3, 32'hB4);
        drain(1'b0);
        for (int i = 0; i < got_c.size(); i++)
            chk($sformatf("t3_cyc%0d", i), 64'(got_c[i]), 64'(t0 + 1 + i));
        clr_q();

        // Three sets under full stall: third dropped
        dout_ready = 1'b0;
        send(32'hC1, 32'hC2, 32'hC3, 32'hC4, t0);
        send(32'hD1, 32'hD2, 32'hD3, 32'hD4, t0);
        send(32'hE1, 32'hE2, 32'hE3, 32'hE4, t0);
        chk("t4_ovf", 64'(ovf), 64'd1);
        chk("t4_drop", 64'(drop_cnt), 64'd1);
        @(posedge clk); #1;
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        chk("t4_ovf_clr", 64'(ovf), 64'd0);
        chk("t4_drop_kept", 64'(drop_cnt), 64'd1);
        dout_ready = 1'b1;
        exp_frame(16'h0004, 32'hC1, 32'hC2, 32'hC3, 32'hC4);
        exp_frame(16'h0005, 32'hD1, 32'hD2, 32'hD3, 32'hD4);
        drain(1'b0);
        clr_q();

        // New set coincides with end-of-frame handshake while shadow is full
        dout_ready = 1'b0;
        send(32'hF1, 32'hF2, 32'hF3, 32'hF4, t0);
        send(32'h91, 32'h92, 32'h93, 32'h94, t0);
        dout_ready = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            if (dout_last) begin
                r11 = 32'h81; r22 = 32'h82; r12_re = 32'h83; r12_im = 32'h84;
                din_valid = 1'b1;
                @(posedge clk); #1;
                din_valid = 1'b0;
                hit = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        chk("t5_hit", 64'(hit), 64'd1);
        exp_frame(16'h0006, 32'hF1, 32'hF2, 32'hF3, 32'hF4);
        exp_frame(16'h0007, 32'h91, 32'h92, 32'h93, 32'h94);
        exp_frame(16'h0008, 32'h81, 32'h82, 32'h83, 32'h84);
        drain(1'b0);
        chk("t5_drop", 64'(drop_cnt), 64'd1);
        chk("t5_ovf", 64'(ovf), 64'd0);
        clr_q();

        // Reset in the middle of a frame
        dout_ready = 1'b1;
        send(32'h71, 32'h72, 32'h73, 32'h74, t0);
        @(posedge clk);
        @(posedge clk); #1;
        chk("t6_r22", 64'(dout), 64'h72);
        rst = 1'b0;
        #1;
        chk("t6_valid", 64'(dout_valid), 64'd0);
        chk("t6_dout", 64'(dout), 64'd0);
        chk("t6_drop", 64'(drop_cnt), 64'd0);
        chk("t6_ovf", 64'(ovf), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        clr_q();
        send(32'h61, 32'h62, 32'h63, 32'h64, t0);
        exp_frame(16'h0000, 32'h61, 32'h62, 32'h63, 32'h64);
        drain(1'b0);
        clr_q();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/uesprit_corr_tx.md
Name: uesprit_corr_tx

Overview:
- Transmit end for the scalar unitary-ESPRIT correlation accumulator.
- Captures each accumulated 2x2 correlation set (r11, r22, r12_re, r12_im) on its single-cycle valid pulse.
- Serialises the set as a 5-word framed stream with valid/ready/last handshake, toward the readout DMA/packetiser.
- A one-deep shadow buffer absorbs a new set arriving mid-frame; further sets are dropped and counted.

Parameters:
- DIN_WIDTH, 32, width of each correlation word and of the output word; must be >= 32.
- SYNC_WORD, 16'hA55A, header sync pattern placed in the upper 16 bits of the header word.
- CNT_WIDTH, 16, width of frame counter and drop counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- r11  in  DIN_WIDTH  accumulated power, channel 1 (unsigned)
- r22  in  DIN_WIDTH  accumulated power, channel 2 (unsigned)
- r12_re  in  DIN_WIDTH  accumulated cross-correlation, real part (signed)
- r12_im  in  DIN_WIDTH  accumulated cross-correlation, imaginary part (signed)
- din_valid  in  1  single-cycle pulse: r* inputs valid this cycle only
- dout  out  DIN_WIDTH  stream word
- dout_valid  out  1  stream word valid
- dout_ready  in  1  downstream accepts word
- dout_last  out  1  asserted with the final word of a frame
- ovf_clr  in  1  synchronous clear of ovf
- ovf  out  1  sticky: at least one set dropped
- drop_cnt  out  CNT_WIDTH  dropped sets; saturates at all-ones

Behaviour:
- Reset (rst low, asynchronous), all outputs 0:
  - dout, dout_valid, dout_last, ovf, drop_cnt all 0.
  - FSM to IDLE; frame counter 0; shadow empty.
- Frame order:
  - HDR = {SYNC_WORD, frame_cnt}, zero-extended above bit 31.
  - Then R11, R22, R12RE, R12IM.
  - dout_last is high only in R12IM.
  - Words are passed bit-exact, with no sign handling.
- FSM states: IDLE, HDR, W_R11, W_R22, W_R12RE, W_R12IM.
  - Advance only on dout_valid && dout_ready.
  - dout_valid is high in every state except IDLE.
- Capture:
  - din_valid in IDLE loads the active register.
  - Next cycle: state HDR, dout_valid=1. Latency is 1 cycle from din_valid to first word.
- Stream rules:
  - dout, dout_last and dout_valid stay stable while dout_valid && !dout_ready.
  - No combinational path from dout_ready to dout_valid.
- din_valid while busy (not IDLE):
  - Shadow empty: load shadow.
  - Shadow full: drop the new set, set ovf, increment drop_cnt (saturating).
- End of frame (R12IM handshake):
  - frame_cnt increments, wrapping at 2^CNT_WIDTH.
  - Shadow full: shadow -> active, next state HDR. Back-to-back frames, no idle cycle.
  - Shadow empty and din_valid same cycle: din -> active, next HDR.
  - Shadow full and din_valid same cycle: shadow -> active, din -> shadow, no drop.
  - Otherwise: IDLE.
- The frame_cnt value in a header equals the number of frames completed before it.
- ovf_clr:
  - Clears ovf only; drop_cnt is untouched.
  - If a drop occurs in the same cycle, set wins (ovf=1).
- Reset mid-frame: frame aborted immediately, dout_valid low asynchronously, shadow discarded.
- No FIFO deeper than active + shadow. Upstream guarantee: accumulation length >> 5 cycles, so drops indicate downstream stall.

Decomposition:
- Package/include: FSM state encoding constants, HDR layout positions (sync [31:16], count [15:0]), FRAME_WORDS = 5.
- One natural sub-module: corr_set_buf. Active + shadow register pair with load/promote/drop logic and drop counter.
- FSM and output mux stay in the top.

Test Plan:
- Single set r11=0x10, r22=0x20, r12_re=0xFFFFFFF0, r12_im=0x5, dout_ready=1:
  - dout sequence 0xA55A0000, 0x10, 0x20, 0xFFFFFFF0, 0x5 on 5 consecutive cycles starting 1 cycle after din_valid.
  - dout_last only on 0x5.
- Backpressure: dout_ready toggled 1,0,0,1 pseudo-randomly → identical word order; words held stable during stalls; no duplicates or losses.
- Two sets 3 cycles apart, ready=1:
  - 10 words back-to-back, no idle cycle between frames.
  - Headers carry counts 0x0000 then 0x0001.
- Three sets while dout_ready=0 through whole frame:
  - First and second sets sent; third dropped.
  - ovf=1, drop_cnt=1.
  - ovf_clr → ovf=0, drop_cnt stays 1.
- din_valid in the same cycle as the R12IM handshake, with shadow full → shadow frame sent next, new set sent after it, drop_cnt unchanged.
- Assert rst low during W_R22:
  - dout_valid=0 immediately; drop_cnt=0.
  - Next set after reset has header count 0x0000.
